// File: rtl/sort_gather_2.sv
// Packs a valid/ready word stream into ordered pairs for the 2-input sorter.
// Optional macro SORT_GATHER_FLUSH_EN: a lone in_last word is padded with all-ones.
module sort_gather_2 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  output logic [WIDTH-1:0] data_0,
  output logic [WIDTH-1:0] data_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pair_count
);

  // state | meaning
  // EMPTY | no word held
  // HALF  | data_0 holds the first word of a pair
  // FULL  | data_0/data_1 hold a complete pair, out_valid asserted
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   handoff;
  logic   load_0;
  logic   load_1;
  logic   fill_1;

  // out_ready reaches in_ready combinationally so a full pair can drain and refill in one cycle
  assign in_ready = (state != FULL) || out_ready;
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;

`ifndef SORT_GATHER_FLUSH_EN
  logic unused_last;
  assign unused_last = in_last;
`endif

  always_comb begin
    state_nxt = state;
    load_0    = 1'b0;
    load_1    = 1'b0;
    fill_1    = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_0    = 1'b1;
          state_nxt = HALF;
`ifdef SORT_GATHER_FLUSH_EN
          if (in_last) begin
            fill_1    = 1'b1;
            state_nxt = FULL;
          end
`endif
        end
      end
      HALF: begin
        if (accept) begin
          load_1    = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (handoff) begin
          if (accept) begin
            load_0    = 1'b1;
            state_nxt = HALF;
          end else begin
            state_nxt = EMPTY;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_0 <= '0;
      data_1 <= '0;
    end else begin
      if (load_0) data_0 <= in_data;
      if (load_1) data_1 <= in_data;
      else if (fill_1) data_1 <= {WIDTH{1'b1}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pair_count <= '0;
    else if (handoff) pair_count <= pair_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_sort_gather_2.sv
// Directed bench for sort_gather_2; counter narrowed to 8 bits so wrap is reachable quickly.
module tb_sort_gather_2;
  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [WIDTH-1:0] data_0;
  logic [WIDTH-1:0] data_1;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] pair_count;

  int n_checks = 0;
  int n_fail   = 0;

  sort_gather_2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .data_0(data_0), .data_1(data_1), .out_valid(out_valid), .out_ready(out_ready),
    .pair_count(pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #12;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_data_0", data_0, 0);
    check_eq("rst_data_1", data_1, 0);
    check_eq("rst_pair_count", pair_count, 0);
    check_eq("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // basic pair 0x5, 0x3
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h5;
    tick();
    check_eq("p1_half_valid", out_valid, 0);
    in_data = 32'h3;
    tick();
    in_valid = 1'b0;
    check_eq("p1_valid", out_valid, 1);
    check_eq("p1_d0", data_0, 32'h5);
    check_eq("p1_d1", data_1, 32'h3);
    check_eq("p1_cnt_before", pair_count, 0);
    tick();
    check_eq("p1_cnt_after", pair_count, 1);
    check_eq("p1_valid_drop", out_valid, 0);

    // backpressure: A,B fill, C stalls until out_ready
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    check_eq("bp_full_valid", out_valid, 1);
    in_data = 32'hC;
    #1;
    check_eq("bp_in_ready_low", in_ready, 0);
    tick();
    check_eq("bp_hold_d0", data_0, 32'hA);
    check_eq("bp_hold_d1", data_1, 32'hB);
    check_eq("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    check_eq("bp_in_ready_comb", in_ready, 1);
    tick();
    check_eq("bp_cnt", pair_count, 2);
    check_eq("bp_c_loaded", data_0, 32'hC);
    check_eq("bp_half_valid", out_valid, 0);
    in_data = 32'hD;
    tick();
    in_valid = 1'b0;
    check_eq("bp_cd_valid", out_valid, 1);
    check_eq("bp_cd_d0", data_0, 32'hC);
    check_eq("bp_cd_d1", data_1, 32'hD);
    tick();
    check_eq("bp_cnt2", pair_count, 3);

    // 200 words back-to-back
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + i;
      #1;
      check_eq("st_in_ready", in_ready, 1);
      tick();
      if (i % 2 == 1) begin
        check_eq("st_valid", out_valid, 1);
        check_eq("st_d0", data_0, 32'h100 + i - 1);
        check_eq("st_d1", data_1, 32'h100 + i);
      end else begin
        check_eq("st_half", out_valid, 0);
      end
    end
    in_valid = 1'b0;
    tick();
    check_eq("st_cnt", pair_count, 103);

    // counter wrap: 152 more pairs reach 255, one more wraps to 0
    for (int i = 0; i < 304; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check_eq("wrap_max", pair_count, 255);
    in_valid = 1'b1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("wrap_zero", pair_count, 0);

    // async reset while HALF holding 0x7
    in_valid = 1'b1; in_data = 32'h7;
    tick();
    in_valid = 1'b0;
    check_eq("rh_d0_held", data_0, 32'h7);
    rst_n = 1'b0;
    #2;
    check_eq("rh_valid", out_valid, 0);
    check_eq("rh_d0", data_0, 0);
    check_eq("rh_in_ready", in_ready, 1);
    rst_n = 1'b1;
    #1;
    in_valid = 1'b1; in_data = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    in_valid = 1'b0;
    check_eq("rh_pair_valid", out_valid, 1);
    check_eq("rh_pair_d0", data_0, 32'h1);
    check_eq("rh_pair_d1", data_1, 32'h2);
    tick();
    check_eq("rh_cnt", pair_count, 1);

    // in_last on a lone word
    out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b1; in_data = 32'h9;
    tick();
    in_last = 1'b0;
`ifdef SORT_GATHER_FLUSH_EN
    in_valid = 1'b0;
    check_eq("fl_valid", out_valid, 1);
    check_eq("fl_d0", data_0, 32'h9);
    check_eq("fl_d1", data_1, 32'hFFFF_FFFF);
`else
    check_eq("fl_no_valid", out_valid, 0);
    check_eq("fl_d0_held", data_0, 32'h9);
    in_data = 32'h4;
    tick();
    in_valid = 1'b0;
    check_eq("fl_pair_valid", out_valid, 1);
    check_eq("fl_pair_d0", data_0, 32'h9);
    check_eq("fl_pair_d1", data_1, 32'h4);
`endif
    out_ready = 1'b1;
    tick();
    check_eq("fl_cnt", pair_count, 2);
    check_eq("fl_drained", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sort_gather_2.md
Name: sort_gather_2

Overview:
Upstream input stage for the 2-input sorting network. Accepts a serial stream of data words over a valid/ready handshake and packs consecutive words into pairs. Each completed pair is presented on data_0/data_1 with out_valid, ready to drive the combinational 2-input sorter directly. Provides one pair of buffering so the stream can continue while a pair waits for the consumer.

Parameters:
WIDTH, 32, data word width; matches data_t.
CNT_W, 16, width of the accepted-pair counter.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_data  input  WIDTH  stream word.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block accepts in_data this cycle.
in_last  input  1  marks the final word of a burst; qualified by in_valid.
data_0  output  WIDTH  first (earlier) word of the pair; feeds sorter data_0.
data_1  output  WIDTH  second (later) word of the pair; feeds sorter data_1.
out_valid  output  1  data_0/data_1 hold a complete pair.
out_ready  input  1  consumer accepts the pair this cycle.
pair_count  output  CNT_W  number of pairs handed off (out_valid && out_ready).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=EMPTY, data_0=0, data_1=0, out_valid=0, pair_count=0, in_ready=1. Assertion mid-operation clears everything immediately and discards any held words or pair.
- An input word is accepted when in_valid && in_ready. A pair is handed off when out_valid && out_ready.
- State machine:
  - EMPTY: no held word. An accepted word goes to data_0 -> HALF.
  - HALF: data_0 holds a word. An accepted word goes to data_1 -> FULL.
  - FULL: out_valid=1.
    - Handoff with no accept -> EMPTY.
    - Handoff and accept in the same cycle: the new word goes to data_0 -> HALF.
- in_ready = (state != FULL) || out_ready. This gives a combinational path from out_ready to in_ready; there is no path from in_valid to in_ready.
- Latency: out_valid rises in the cycle after the second word of a pair is accepted. Sustained throughput is one word per cycle.
- out_valid is registered. data_0/data_1 are stable while out_valid=1 && !out_ready.
- pair_count increments by 1 per handoff and wraps from 2^CNT_W-1 to 0.
- Word order is preserved: data_0 is always the earlier word.
- Without the optional feature:
  - in_last is ignored.
  - An odd final word stays in HALF indefinitely and pairs with the next burst's first word.
- No data arithmetic is performed. Words pass through bit-exact.

Optional Feature:
SORT_GATHER_FLUSH_EN
- Defined: if a word is accepted with in_last=1 while in EMPTY, the next state is FULL with data_1 = all-ones ({WIDTH{1'b1}}). All-ones is the maximum value, so after sorting it lands in sort_1.
- Defined: in_last on a word that completes a pair behaves normally.
- Not defined: in_last is unused and the behaviour above applies.

Test Plan:
- Reset, then stream 0x5, 0x3 back-to-back with out_ready=1 -> cycle after second accept: out_valid=1, data_0=0x5, data_1=0x3, pair_count goes 0->1.
- Stream 0xA, 0xB, 0xC, 0xD with out_ready=0 -> after 0xA/0xB the block enters FULL, in_ready=0, and 0xC stalls. Raise out_ready -> pair (0xA,0xB) handed off, 0xC accepted the same cycle, then (0xC,0xD) appears.
- Continuous in_valid=1 with out_ready=1 for 200 words -> one word accepted per cycle, 100 pairs, pair_count=100, order preserved.
- Preset pair_count to 0xFFFF by driving 65535 pairs, then hand off one more -> pair_count=0x0000.
- Assert rst_n=0 while in HALF holding 0x7 -> out_valid=0, data_0=0 immediately. After release, stream 0x1, 0x2 -> pair (0x1,0x2); 0x7 is never seen.
- With SORT_GATHER_FLUSH_EN: send single word 0x9 with in_last=1 -> next cycle out_valid=1, data_0=0x9, data_1=0xFFFFFFFF. Without the macro: out_valid stays 0 and the next word 0x4 forms the pair (0x9,0x4).
